// File: rtl/mode1_pkg.sv
// Shared types and constants for the 8255A Mode 1 strobed port.
package mode1_pkg;

    typedef enum logic [1:0] {
        IN_EMPTY,
        IN_FULL,
        OUT_EMPTY,
        OUT_FULL
    } state_e;

    localparam int unsigned SYNC_STAGES_DEF = 2;

    localparam int unsigned PIN_RD  = 0;
    localparam int unsigned PIN_WR  = 1;
    localparam int unsigned PIN_STB = 2;
    localparam int unsigned PIN_ACK = 3;
    localparam int unsigned NUM_PINS = 4;

    function automatic logic is_in_state(input state_e s);
        return (s == IN_EMPTY) || (s == IN_FULL);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an active-low strobe with rise/fall pulses.
module sync_edge_detect #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Cleared to 1 so an idle strobe never produces a spurious edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = ~prev_q &  sync_q[STAGES-1];
    assign fall_o =  prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/mode1_handshake_port.sv
// 8255A Mode 1 port: strobed input latch / strobed output latch with
// IBF, OBF_n, INTR and a sticky overrun flag.
module mode1_handshake_port
    import mode1_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_out,
    input  logic             INTE,
    input  logic             RD,
    input  logic             WR,
    input  logic [WIDTH-1:0] CpuDataIn,
    output logic [WIDTH-1:0] CpuDataOut,
    input  logic [WIDTH-1:0] PortIn,
    output logic [WIDTH-1:0] PortOut,
    output logic             PortOE,
    input  logic             STB,
    input  logic             ACK,
    output logic             IBF,
    output logic             OBF_n,
    output logic             INTR,
    output logic             OVR
);

    logic [NUM_PINS-1:0] pin_raw, pin_rise, pin_fall;
    logic rd_fall, rd_rise, wr_fall, wr_rise, stb_fall, stb_rise, ack_fall, ack_rise;

    assign pin_raw = {ACK, STB, WR, RD};

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_sync
        sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (pin_raw[g]),
            .rise_o(pin_rise[g]),
            .fall_o(pin_fall[g])
        );
    end

    assign rd_fall  = pin_fall[PIN_RD];
    assign rd_rise  = pin_rise[PIN_RD];
    assign wr_fall  = pin_fall[PIN_WR];
    assign wr_rise  = pin_rise[PIN_WR];
    assign stb_fall = pin_fall[PIN_STB];
    assign stb_rise = pin_rise[PIN_STB];
    assign ack_fall = pin_fall[PIN_ACK];
    assign ack_rise = pin_rise[PIN_ACK];

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cpu_q, cpu_d, port_q, port_d;
    logic             ibf_q, ibf_d, obf_n_q, obf_n_d, intr_q, intr_d, ovr_q, ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IN_EMPTY;
            cpu_q   <= '0;
            port_q  <= '0;
            ibf_q   <= 1'b0;
            obf_n_q <= 1'b1;
            intr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cpu_q   <= cpu_d;
            port_q  <= port_d;
            ibf_q   <= ibf_d;
            obf_n_q <= obf_n_d;
            intr_q  <= intr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cpu_d   = cpu_q;
        port_d  = port_q;
        ibf_d   = ibf_q;
        obf_n_d = obf_n_q;
        intr_d  = intr_q;
        ovr_d   = ovr_q;

        // A state whose direction disagrees with In_out means the direction
        // changed (or reset landed in the other mode): fall back to idle flags.
        if (In_out != is_in_state(state_q)) begin
            state_d = In_out ? IN_EMPTY : OUT_EMPTY;
            ibf_d   = 1'b0;
            obf_n_d = 1'b1;
            intr_d  = 1'b0;
            ovr_d   = 1'b0;
        end else if (In_out) begin
            if (stb_rise && state_q == IN_FULL) intr_d = 1'b1;
            if (rd_fall) intr_d = 1'b0;
            if (rd_rise) begin
                ibf_d   = 1'b0;
                ovr_d   = 1'b0;
                state_d = IN_EMPTY;
            end
            // Strobe into a full latch is flagged even when RD empties it this cycle.
            if (stb_fall) begin
                if (state_q == IN_EMPTY) begin
                    cpu_d   = PortIn;
                    ibf_d   = 1'b1;
                    state_d = IN_FULL;
                end else begin
                    ovr_d   = 1'b1;
                end
            end
        end else begin
            if (ack_rise && obf_n_q) intr_d = 1'b1;
            if (wr_fall) intr_d = 1'b0;
            if (ack_fall && state_q == OUT_FULL) begin
                obf_n_d = 1'b1;
                state_d = OUT_EMPTY;
            end
            if (wr_rise) begin
                port_d  = CpuDataIn;
                obf_n_d = 1'b0;
                state_d = OUT_FULL;
            end
        end

        if (!INTE) intr_d = 1'b0;
    end

    assign CpuDataOut = cpu_q;
    assign PortOut    = port_q;
    assign IBF        = ibf_q;
    assign OBF_n      = obf_n_q;
    assign INTR       = intr_q;
    assign OVR        = ovr_q;
    assign PortOE     = ~In_out;

endmodule

// File: tb/tb_mode1_handshake_port.sv
// Scoreboard bench for mode1_handshake_port: directed handshakes, corner
// cases and randomized strobe traffic against an event-level reference model.
module tb_mode1_handshake_port;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       In_out = 1'b1;
    logic       INTE = 1'b0;
    logic       RD = 1'b1, WR = 1'b1, STB = 1'b1, ACK = 1'b1;
    logic [7:0] CpuDataIn = 8'h00, PortIn = 8'h00;
    logic [7:0] CpuDataOut, PortOut;
    logic       PortOE, IBF, OBF_n, INTR, OVR;

    mode1_handshake_port #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .In_out(In_out), .INTE(INTE),
        .RD(RD), .WR(WR), .CpuDataIn(CpuDataIn), .CpuDataOut(CpuDataOut),
        .PortIn(PortIn), .PortOut(PortOut), .PortOE(PortOE),
        .STB(STB), .ACK(ACK), .IBF(IBF), .OBF_n(OBF_n), .INTR(INTR), .OVR(OVR)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] cpu;
        logic [7:0] port;
        logic       ibf, obf_n, intr, ovr, oe;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: architectural state updated per handshake event.
    logic [7:0] m_cpu = 8'h00, m_port = 8'h00;
    logic       m_ibf = 1'b0, m_obf_n = 1'b1, m_intr = 1'b0, m_ovr = 1'b0;

    function automatic string pin_name(input int p);
        case (p)
            0: return "RD";
            1: return "WR";
            2: return "STB";
            default: return "ACK";
        endcase
    endfunction

    task automatic model_reset();
        m_cpu = 8'h00; m_port = 8'h00;
        m_ibf = 1'b0; m_obf_n = 1'b1; m_intr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_edge(input int p, input bit fall, input logic [7:0] d);
        if (In_out) begin
            if (p == 0) begin
                if (fall) m_intr = 1'b0;
                else begin m_ibf = 1'b0; m_ovr = 1'b0; end
            end else if (p == 2) begin
                if (fall) begin
                    if (m_ibf) m_ovr = 1'b1;
                    else begin m_cpu = d; m_ibf = 1'b1; end
                end else if (m_ibf && INTE) m_intr = 1'b1;
            end
        end else begin
            if (p == 1) begin
                if (fall) m_intr = 1'b0;
                else begin m_port = d; m_obf_n = 1'b0; end
            end else if (p == 3) begin
                if (fall) m_obf_n = 1'b1;
                else if (m_obf_n && INTE) m_intr = 1'b1;
            end
        end
    endtask

    task automatic expect_now(input string nm);
        snap_t s;
        s.name = nm; s.cpu = m_cpu; s.port = m_port; s.ibf = m_ibf;
        s.obf_n = m_obf_n; s.intr = m_intr; s.ovr = m_ovr; s.oe = ~In_out;
        exp_q.push_back(s);
        @(negedge clk); #1;
    endtask

    task automatic set_pin(input int p, input logic v);
        case (p)
            0: RD = v;
            1: WR = v;
            2: STB = v;
            default: ACK = v;
        endcase
    endtask

    // Drive one pin edge; state must hold for two clocks and update on the third.
    task automatic pin_edge(input int p, input logic v, input logic [7:0] d);
        string nm;
        nm = $sformatf("%s_%s", pin_name(p), v ? "rise" : "fall");
        set_pin(p, v);
        @(posedge clk); @(posedge clk); #1;
        expect_now({nm, "_pre"});
        @(posedge clk); #1;
        model_edge(p, !v, d);
        expect_now(nm);
    endtask

    task automatic pulse(input int p, input logic [7:0] d, input int low, input int gap);
        if (p == 2) PortIn = d;
        if (p == 1) CpuDataIn = d;
        pin_edge(p, 1'b0, d);
        repeat (low - 3) @(posedge clk);
        #1;
        pin_edge(p, 1'b1, d);
        PortIn = 8'($urandom);
        CpuDataIn = 8'($urandom);
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic set_inte(input logic v);
        INTE = v;
        @(posedge clk); #1;
        if (!v) m_intr = 1'b0;
        expect_now("inte");
    endtask

    task automatic set_dir(input logic v);
        if (v != In_out) begin
            In_out = v;
            @(posedge clk); #1;
            m_ibf = 1'b0; m_obf_n = 1'b1; m_intr = 1'b0; m_ovr = 1'b0;
            expect_now("dir_change");
        end
    endtask

    // Monitor: compares the DUT against each queued expectation.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({CpuDataOut, PortOut, IBF, OBF_n, INTR, OVR, PortOE} !==
                    {e.cpu, e.port, e.ibf, e.obf_n, e.intr, e.ovr, e.oe}) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got cpu=%h port=%h ibf=%b obf_n=%b intr=%b ovr=%b oe=%b, want cpu=%h port=%h ibf=%b obf_n=%b intr=%b ovr=%b oe=%b",
                             e.name, $time, CpuDataOut, PortOut, IBF, OBF_n, INTR, OVR, PortOE,
                             e.cpu, e.port, e.ibf, e.obf_n, e.intr, e.ovr, e.oe);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        expect_now("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_now("reset_idle");

        // Input handshake
        set_inte(1'b1);
        pulse(2, 8'hA5, 6, 2);
        pulse(0, 8'h00, 4, 2);

        // Output handshake
        set_dir(1'b0);
        pulse(1, 8'h3C, 4, 2);
        pulse(3, 8'h00, 5, 2);

        // Overrun
        set_dir(1'b1);
        pulse(2, 8'h11, 5, 1);
        pulse(2, 8'h22, 5, 1);
        pulse(0, 8'h00, 4, 1);

        // INTE gating
        set_inte(1'b0);
        pulse(2, 8'h5C, 6, 1);
        pulse(0, 8'h00, 4, 1);
        set_inte(1'b1);
        pulse(2, 8'h77, 5, 1);
        set_inte(1'b0);
        set_inte(1'b1);
        pulse(0, 8'h00, 4, 1);

        // Direction change with IBF set
        pulse(2, 8'h9E, 4, 1);
        set_dir(1'b0);
        set_dir(1'b1);

        // Same-cycle RD rise and STB fall in IN_FULL
        pulse(2, 8'hC3, 4, 1);
        pin_edge(0, 1'b0, 8'h00);
        PortIn = 8'h5A;
        STB = 1'b0; RD = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        expect_now("rd_stb_same_pre");
        @(posedge clk); #1;
        m_ibf = 1'b0; m_ovr = 1'b1;
        expect_now("rd_stb_same");
        repeat (2) @(posedge clk);
        #1;
        pin_edge(2, 1'b1, 8'h5A);
        pulse(0, 8'h00, 4, 1);

        // Same-cycle WR rise and ACK fall in OUT_FULL
        set_dir(1'b0);
        pulse(1, 8'h1F, 4, 1);
        pin_edge(1, 1'b0, 8'h1F);
        CpuDataIn = 8'hE4;
        WR = 1'b1; ACK = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        expect_now("wr_ack_same_pre");
        @(posedge clk); #1;
        m_port = 8'hE4; m_obf_n = 1'b0;
        expect_now("wr_ack_same");
        repeat (2) @(posedge clk);
        #1;
        pin_edge(3, 1'b1, 8'h00);

        // Randomized traffic, including strobes in the wrong direction
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 5 || r == 9)
                pulse(int'($urandom_range(0, 3)), 8'($urandom),
                      int'($urandom_range(4, 7)), int'($urandom_range(0, 2)));
            else if (r <= 7)
                set_inte(1'($urandom));
            else
                set_dir(1'($urandom));
        end

        // Reset mid-handshake
        set_dir(1'b1);
        set_inte(1'b1);
        pulse(2, 8'h6B, 4, 1);
        PortIn = 8'h33;
        STB = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        expect_now("reset_async");
        STB = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_now("reset_release");

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
